// File: rtl/wrr_pifo_pkg.sv
// -----------------------------------------------------------------------------
// wrr_pifo_pkg
// Shared definitions for the WRR rank engine and its PIFO dequeue companion.
//   - Rank word layout {valid, overflow, round, addr}, MSB first, with the
//     field widths and bit offsets.
//   - ROUND_MAX, the last round value before the engine wraps to 0 and
//     increments the overflow field.
//   - rank_before(a, b): serial-number compare of the {overflow, round} key.
//   - rank_word(): builds a valid rank word from its fields.
//   - slot_sel_e: next-state select used by each PIFO storage cell.
// -----------------------------------------------------------------------------
package wrr_pifo_pkg;

    localparam int OVF_W   = 1;
    localparam int ROUND_W = 18;
    localparam int ADDR_W  = 12;
    localparam int RANK_W  = 1 + OVF_W + ROUND_W + ADDR_W;
    localparam int KEY_W   = OVF_W + ROUND_W;

    localparam int ADDR_LSB  = 0;
    localparam int ADDR_MSB  = ADDR_LSB + ADDR_W - 1;
    localparam int ROUND_LSB = ADDR_MSB + 1;
    localparam int ROUND_MSB = ROUND_LSB + ROUND_W - 1;
    localparam int OVF_LSB   = ROUND_MSB + 1;
    localparam int OVF_MSB   = OVF_LSB + OVF_W - 1;
    localparam int VALID_BIT = OVF_MSB + 1;

    localparam logic [ROUND_W-1:0] ROUND_MAX = '1;

    typedef logic [RANK_W-1:0] rank_t;
    typedef logic [KEY_W-1:0]  key_t;

    typedef enum logic [1:0] {
        SEL_HOLD = 2'd0,   // keep current contents
        SEL_UP   = 2'd1,   // take slot i+1 (shift toward head)
        SEL_DN   = 2'd2,   // take slot i-1 (shift away from head)
        SEL_NEW  = 2'd3    // take the incoming word
    } slot_sel_e;

    // A is earlier than B when (K_A - K_B) mod 2^KEY_W has its MSB set.
    // Keys are assumed to lie within half the key space of each other,
    // which is what makes the ROUND_MAX -> 0 wrap order correctly.
    function automatic logic rank_before(input rank_t a, input rank_t b);
        key_t diff;
        diff = a[OVF_MSB:ROUND_LSB] - b[OVF_MSB:ROUND_LSB];
        return diff[KEY_W-1];
    endfunction

    function automatic rank_t rank_word(input logic [OVF_W-1:0]   ovf,
                                        input logic [ROUND_W-1:0] round,
                                        input logic [ADDR_W-1:0]  addr);
        rank_t w;
        w                     = '0;
        w[VALID_BIT]          = 1'b1;
        w[OVF_MSB:OVF_LSB]    = ovf;
        w[ROUND_MSB:ROUND_LSB] = round;
        w[ADDR_MSB:ADDR_LSB]  = addr;
        return w;
    endfunction

endpackage

// File: rtl/wrr_pifo_dequeue_slot.sv
// -----------------------------------------------------------------------------
// pifo_slot
// One storage cell of the sorted shift-register PIFO (index IDX, 0 = head).
// Ports:
//   clk, rstn          clock, asynchronous active-low reset
//   ins, pop           broadcast insert / pop strobes for this cycle
//   ins_pos            broadcast final slot index of the inserted word
//   new_data           word being inserted
//   up_valid/up_data   contents of slot IDX+1
//   dn_valid/dn_data   contents of slot IDX-1
//   valid, data        this slot's registered contents
// -----------------------------------------------------------------------------
module pifo_slot
    import wrr_pifo_pkg::*;
#(
    parameter int PIFO_WIDTH  = 32,
    parameter int COUNT_WIDTH = 5,
    parameter int IDX         = 0
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   ins,
    input  logic                   pop,
    input  logic [COUNT_WIDTH-1:0] ins_pos,
    input  logic [PIFO_WIDTH-1:0]  new_data,
    input  logic                   up_valid,
    input  logic [PIFO_WIDTH-1:0]  up_data,
    input  logic                   dn_valid,
    input  logic [PIFO_WIDTH-1:0]  dn_data,
    output logic                   valid,
    output logic [PIFO_WIDTH-1:0]  data
);

    localparam logic [COUNT_WIDTH-1:0] MY_IDX = COUNT_WIDTH'(IDX);

    slot_sel_e sel;
    logic      valid_reg;
    logic [PIFO_WIDTH-1:0] data_reg;

    // With pop and insert together, ins_pos is an index into the post-pop
    // array: slots below it shift toward the head, slots above it stay put
    // (the pop shift and the insert shift cancel).
    always_comb begin
        sel = SEL_HOLD;
        if (ins && pop) begin
            if (MY_IDX < ins_pos)       sel = SEL_UP;
            else if (MY_IDX == ins_pos) sel = SEL_NEW;
            else                        sel = SEL_HOLD;
        end else if (ins) begin
            if (MY_IDX < ins_pos)       sel = SEL_HOLD;
            else if (MY_IDX == ins_pos) sel = SEL_NEW;
            else                        sel = SEL_DN;
        end else if (pop) begin
            sel = SEL_UP;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            valid_reg <= 1'b0;
            data_reg  <= '0;
        end else begin
            case (sel)
                SEL_UP: begin
                    valid_reg <= up_valid;
                    data_reg  <= up_data;
                end
                SEL_DN: begin
                    valid_reg <= dn_valid;
                    data_reg  <= dn_data;
                end
                SEL_NEW: begin
                    valid_reg <= 1'b1;
                    data_reg  <= new_data;
                end
                default: begin
                    valid_reg <= valid_reg;
                    data_reg  <= data_reg;
                end
            endcase
        end
    end

    assign valid = valid_reg;
    assign data  = data_reg;

endmodule

// File: rtl/wrr_pifo_dequeue.sv
// -----------------------------------------------------------------------------
// wrr_pifo_dequeue
// Sorted shift-register PIFO holding WRR rank words; pops the earliest
// {overflow, round} key on request and feeds the popped key back to the rank
// engine as the last dequeued global round.
// Ports:
//   clk, rstn                 clock, asynchronous active-low reset
//   enq_valid/enq_ready/enq_data   rank word input (ready may depend on deq_req)
//   deq_req                   pop request
//   deq_valid/deq_data        popped word, one-cycle pulse after the pop;
//                             deq_data holds the last popped word
//   last_pifo_valid/_overflow/_round   popped-key feedback to the rank engine
//   occupancy                 current entry count
// -----------------------------------------------------------------------------
module wrr_pifo_dequeue
    import wrr_pifo_pkg::*;
#(
    parameter int DEPTH               = 16,
    parameter int PIFO_OVERFLOW_WIDTH = OVF_W,
    parameter int PIFO_ROUND_WIDTH    = ROUND_W,
    parameter int PIFO_ADDR_WIDTH     = ADDR_W,
    parameter int PIFO_WIDTH          = RANK_W,
    parameter int COUNT_WIDTH         = 5
) (
    input  logic                           clk,
    input  logic                           rstn,
    input  logic                           enq_valid,
    output logic                           enq_ready,
    input  logic [PIFO_WIDTH-1:0]          enq_data,
    input  logic                           deq_req,
    output logic                           deq_valid,
    output logic [PIFO_WIDTH-1:0]          deq_data,
    output logic                           last_pifo_valid,
    output logic [PIFO_OVERFLOW_WIDTH-1:0] last_pifo_overflow,
    output logic [PIFO_ROUND_WIDTH-1:0]    last_pifo_round,
    output logic [COUNT_WIDTH-1:0]         occupancy
);

    localparam int OVF_OFS   = PIFO_ADDR_WIDTH + PIFO_ROUND_WIDTH;
    localparam int ROUND_OFS = PIFO_ADDR_WIDTH;

    logic [DEPTH-1:0]      slot_valid;
    logic [PIFO_WIDTH-1:0] slot_data [DEPTH];

    logic [COUNT_WIDTH-1:0] count_reg, count_next;
    logic                   enq_fire, deq_fire;
    logic [DEPTH-1:0]       not_later;
    logic [COUNT_WIDTH-1:0] le_cnt, ins_pos;

    logic                           deq_valid_reg;
    logic [PIFO_WIDTH-1:0]          deq_data_reg;
    logic                           last_valid_reg;
    logic [PIFO_OVERFLOW_WIDTH-1:0] last_ovf_reg;
    logic [PIFO_ROUND_WIDTH-1:0]    last_round_reg;

    // A pop frees a slot for a same-cycle insert even when full. Ready is
    // held low while reset is asserted.
    assign enq_ready = rstn & ((count_reg < COUNT_WIDTH'(DEPTH)) | deq_req);
    assign enq_fire  = enq_valid & enq_ready;
    // No bypass: a pop against an empty queue is simply ignored.
    assign deq_fire  = deq_req & (count_reg != '0);

    // Insert position = number of stored entries not later than the new key,
    // so equal keys land behind existing ones (FIFO among ties). On a
    // simultaneous pop the head is excluded from the count.
    always_comb begin
        not_later = '0;
        le_cnt    = '0;
        for (int i = 0; i < DEPTH; i++) begin
            not_later[i] = slot_valid[i] & ~rank_before(enq_data, slot_data[i]);
            le_cnt       = le_cnt + COUNT_WIDTH'(not_later[i]);
        end
        ins_pos = le_cnt - ((deq_fire && not_later[0]) ? COUNT_WIDTH'(1) : '0);
    end

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_slot
            logic                  up_valid, dn_valid;
            logic [PIFO_WIDTH-1:0] up_data, dn_data;

            if (gi == DEPTH - 1) begin : g_tail
                assign up_valid = 1'b0;
                assign up_data  = '0;
            end else begin : g_body
                assign up_valid = slot_valid[gi+1];
                assign up_data  = slot_data[gi+1];
            end

            if (gi == 0) begin : g_head
                assign dn_valid = 1'b0;
                assign dn_data  = '0;
            end else begin : g_rest
                assign dn_valid = slot_valid[gi-1];
                assign dn_data  = slot_data[gi-1];
            end

            pifo_slot #(
                .PIFO_WIDTH  (PIFO_WIDTH),
                .COUNT_WIDTH (COUNT_WIDTH),
                .IDX         (gi)
            ) u_slot (
                .clk      (clk),
                .rstn     (rstn),
                .ins      (enq_fire),
                .pop      (deq_fire),
                .ins_pos  (ins_pos),
                .new_data (enq_data),
                .up_valid (up_valid),
                .up_data  (up_data),
                .dn_valid (dn_valid),
                .dn_data  (dn_data),
                .valid    (slot_valid[gi]),
                .data     (slot_data[gi])
            );
        end
    endgenerate

    always_comb begin
        count_next = count_reg;
        case ({enq_fire, deq_fire})
            2'b10:   count_next = count_reg + COUNT_WIDTH'(1);
            2'b01:   count_next = count_reg - COUNT_WIDTH'(1);
            default: count_next = count_reg;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            count_reg      <= '0;
            deq_valid_reg  <= 1'b0;
            deq_data_reg   <= '0;
            last_valid_reg <= 1'b0;
            last_ovf_reg   <= '0;
            last_round_reg <= '0;
        end else begin
            count_reg      <= count_next;
            deq_valid_reg  <= deq_fire;
            last_valid_reg <= deq_fire;
            if (deq_fire) begin
                deq_data_reg   <= slot_data[0];
                last_ovf_reg   <= slot_data[0][OVF_OFS +: PIFO_OVERFLOW_WIDTH];
                last_round_reg <= slot_data[0][ROUND_OFS +: PIFO_ROUND_WIDTH];
            end
        end
    end

    assign occupancy          = count_reg;
    assign deq_valid          = deq_valid_reg;
    assign deq_data           = deq_data_reg;
    assign last_pifo_valid    = last_valid_reg;
    assign last_pifo_overflow = last_ovf_reg;
    assign last_pifo_round    = last_round_reg;

endmodule

// File: tb/tb_wrr_pifo_dequeue.sv
// -----------------------------------------------------------------------------
// tb_wrr_pifo_dequeue
// Directed vector table, hand-written full/reset sequences, and a random soak
// against a sorted-list reference model.
// -----------------------------------------------------------------------------
module tb_wrr_pifo_dequeue;
    import wrr_pifo_pkg::*;

    localparam int DEPTH = 16;

    logic        clk = 1'b0;
    logic        rstn;
    logic        enq_valid;
    logic        enq_ready;
    logic [31:0] enq_data;
    logic        deq_req;
    logic        deq_valid;
    logic [31:0] deq_data;
    logic        last_pifo_valid;
    logic [0:0]  last_pifo_overflow;
    logic [17:0] last_pifo_round;
    logic [4:0]  occupancy;

    always #5 clk = ~clk;

    wrr_pifo_dequeue #(
        .DEPTH               (DEPTH),
        .PIFO_OVERFLOW_WIDTH (1),
        .PIFO_ROUND_WIDTH    (18),
        .PIFO_ADDR_WIDTH     (12),
        .PIFO_WIDTH          (32),
        .COUNT_WIDTH         (5)
    ) dut (
        .clk                (clk),
        .rstn               (rstn),
        .enq_valid          (enq_valid),
        .enq_ready          (enq_ready),
        .enq_data           (enq_data),
        .deq_req            (deq_req),
        .deq_valid          (deq_valid),
        .deq_data           (deq_data),
        .last_pifo_valid    (last_pifo_valid),
        .last_pifo_overflow (last_pifo_overflow),
        .last_pifo_round    (last_pifo_round),
        .occupancy          (occupancy)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] w(input int o, input int r, input int a);
        return rank_word(OVF_W'(o), ROUND_W'(r), ADDR_W'(a));
    endfunction

    typedef struct {
        logic        ev;
        logic [31:0] ed;
        logic        dr;
        logic        x_rdy;
        logic        x_dv;
        logic [31:0] x_dd;
        logic [0:0]  x_lovf;
        logic [17:0] x_lround;
        logic [4:0]  x_occ;
    } vec_t;

    function automatic vec_t mk(input int ev, input logic [31:0] ed, input int dr,
                                input int xr, input int xd, input logic [31:0] xdd,
                                input int lo, input int lr, input int occ);
        vec_t v;
        v.ev = 1'(ev); v.ed = ed; v.dr = 1'(dr);
        v.x_rdy = 1'(xr); v.x_dv = 1'(xd); v.x_dd = xdd;
        v.x_lovf = 1'(lo); v.x_lround = 18'(lr); v.x_occ = 5'(occ);
        return v;
    endfunction

    // Reference ordering on the 19-bit key, evaluated on integers.
    function automatic bit m_before(input logic [31:0] a, input logic [31:0] b);
        int ka, kb, d;
        ka = int'(a[30:12]);
        kb = int'(b[30:12]);
        d  = (ka - kb) & 32'h7FFFF;
        return d >= 32'h40000;
    endfunction

    vec_t        tbl[$];
    logic [31:0] mq[$];
    logic [31:0] m_dd;
    logic [0:0]  m_lovf;
    logic [17:0] m_lround;
    logic [31:0] popped;
    logic [18:0] key;
    bit          ev, dr, ef, df, x_rdy;
    int          pos;

    initial begin
        rstn = 1'b0; enq_valid = 1'b0; enq_data = '0; deq_req = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_occ", 32'(occupancy), 0);
        chk("rst_rdy", 32'(enq_ready), 0);
        chk("rst_dv", 32'(deq_valid), 0);
        rstn = 1'b1;
        #1;
        chk("rel_rdy", 32'(enq_ready), 1);
        $display("reset released");

        // ---------------- directed table ----------------
        tbl.push_back(mk(1, w(0, 7, 1), 0, 1, 0, 0, 0, 0, 1));
        tbl.push_back(mk(1, w(0, 3, 2), 0, 1, 0, 0, 0, 0, 2));
        tbl.push_back(mk(1, w(0, 5, 3), 0, 1, 0, 0, 0, 0, 3));
        tbl.push_back(mk(1, w(0, 3, 4), 0, 1, 0, 0, 0, 0, 4));
        tbl.push_back(mk(0, 0, 1, 1, 1, w(0, 3, 2), 0, 3, 3));
        tbl.push_back(mk(0, 0, 1, 1, 1, w(0, 3, 4), 0, 3, 2));
        tbl.push_back(mk(0, 0, 1, 1, 1, w(0, 5, 3), 0, 5, 1));
        tbl.push_back(mk(0, 0, 1, 1, 1, w(0, 7, 1), 0, 7, 0));
        tbl.push_back(mk(0, 0, 1, 1, 0, 0, 0, 7, 0));
        tbl.push_back(mk(1, w(0, int'(ROUND_MAX), 5), 0, 1, 0, 0, 0, 7, 1));
        tbl.push_back(mk(1, w(1, 0, 6), 0, 1, 0, 0, 0, 7, 2));
        tbl.push_back(mk(0, 0, 1, 1, 1, w(0, int'(ROUND_MAX), 5), 0, int'(ROUND_MAX), 1));
        tbl.push_back(mk(0, 0, 1, 1, 1, w(1, 0, 6), 1, 0, 0));
        tbl.push_back(mk(1, w(0, 9, 7), 1, 1, 0, 0, 1, 0, 1));
        tbl.push_back(mk(0, 0, 1, 1, 1, w(0, 9, 7), 0, 9, 0));

        for (int i = 0; i < tbl.size(); i++) begin
            enq_valid = tbl[i].ev; enq_data = tbl[i].ed; deq_req = tbl[i].dr;
            #1;
            chk("vec_rdy", 32'(enq_ready), 32'(tbl[i].x_rdy));
            tick();
            enq_valid = 1'b0; deq_req = 1'b0;
            chk("vec_dv", 32'(deq_valid), 32'(tbl[i].x_dv));
            chk("vec_lv", 32'(last_pifo_valid), 32'(tbl[i].x_dv));
            if (tbl[i].x_dv) chk("vec_dd", deq_data, tbl[i].x_dd);
            chk("vec_lovf", 32'(last_pifo_overflow), 32'(tbl[i].x_lovf));
            chk("vec_lround", 32'(last_pifo_round), 32'(tbl[i].x_lround));
            chk("vec_occ", 32'(occupancy), 32'(tbl[i].x_occ));
            $display("vec %0d: enq=%0d deq=%0d dv=%0d dd=%h occ=%0d", i, tbl[i].ev, tbl[i].dr,
                     deq_valid, deq_data, occupancy);
        end

        // ---------------- full + simultaneous ----------------
        for (int i = 0; i < DEPTH; i++) begin
            enq_valid = 1'b1; enq_data = w(0, 10, i);
            tick();
        end
        enq_data = w(0, 2, 8'h55); deq_req = 1'b0;
        #1;
        chk("full_occ", 32'(occupancy), 16);
        chk("full_rdy", 32'(enq_ready), 0);
        deq_req = 1'b1;
        #1;
        chk("full_rdy_pop", 32'(enq_ready), 1);
        tick();
        enq_valid = 1'b0;
        chk("full_dv", 32'(deq_valid), 1);
        chk("full_dd", deq_data, w(0, 10, 0));
        chk("full_occ_keep", 32'(occupancy), 16);
        $display("full swap: dd=%h occ=%0d", deq_data, occupancy);
        tick();
        chk("full_next_dd", deq_data, w(0, 2, 8'h55));
        chk("full_next_occ", 32'(occupancy), 15);
        $display("full next pop: dd=%h occ=%0d", deq_data, occupancy);
        for (int k = 1; k <= 10; k++) begin
            tick();
            chk("drain_dd", deq_data, w(0, 10, k));
            chk("drain_occ", 32'(occupancy), 32'(15 - k));
            $display("drain pop: dd=%h occ=%0d", deq_data, occupancy);
        end
        deq_req = 1'b0;

        // ---------------- reset mid-stream (5 entries stored) ----------------
        rstn = 1'b0;
        #2;
        chk("mrst_occ", 32'(occupancy), 0);
        chk("mrst_rdy", 32'(enq_ready), 0);
        chk("mrst_dv", 32'(deq_valid), 0);
        chk("mrst_dd", deq_data, 0);
        chk("mrst_lv", 32'(last_pifo_valid), 0);
        chk("mrst_lovf", 32'(last_pifo_overflow), 0);
        chk("mrst_lround", 32'(last_pifo_round), 0);
        @(posedge clk);
        #1;
        rstn = 1'b1;
        #1;
        chk("mrst_rel_rdy", 32'(enq_ready), 1);
        deq_req = 1'b1;
        tick();
        deq_req = 1'b0;
        chk("mrst_empty_dv", 32'(deq_valid), 0);
        chk("mrst_empty_lv", 32'(last_pifo_valid), 0);
        chk("mrst_empty_occ", 32'(occupancy), 0);
        $display("mid-stream reset: occ=%0d dv=%0d", occupancy, deq_valid);

        // ---------------- random soak ----------------
        mq.delete();
        m_dd = '0; m_lovf = '0; m_lround = '0;
        for (int cyc = 0; cyc < 10000; cyc++) begin
            if (((cyc / 400) % 2) == 0) begin
                ev = ($urandom_range(0, 3) != 0);
                dr = ($urandom_range(0, 3) == 0);
            end else begin
                ev = ($urandom_range(0, 3) == 0);
                dr = ($urandom_range(0, 3) != 0);
            end
            key = 19'h3FFF8 + 19'($urandom_range(0, 15));
            enq_valid = ev; deq_req = dr;
            enq_data = {1'b1, key, 12'(cyc)};
            #1;
            x_rdy = (mq.size() < DEPTH) || dr;
            chk("soak_rdy", 32'(enq_ready), 32'(x_rdy));
            ef = ev && x_rdy;
            df = dr && (mq.size() != 0);
            if (df) begin
                popped   = mq.pop_front();
                m_dd     = popped;
                m_lovf   = popped[30];
                m_lround = popped[29:12];
            end
            if (ef) begin
                pos = 0;
                foreach (mq[j]) if (!m_before(enq_data, mq[j])) pos++;
                mq.insert(pos, enq_data);
            end
            tick();
            chk("soak_dv", 32'(deq_valid), 32'(df));
            chk("soak_dd", deq_data, m_dd);
            chk("soak_lv", 32'(last_pifo_valid), 32'(df));
            chk("soak_lovf", 32'(last_pifo_overflow), 32'(m_lovf));
            chk("soak_lround", 32'(last_pifo_round), 32'(m_lround));
            chk("soak_occ", 32'(occupancy), 32'(mq.size()));
        end
        enq_valid = 1'b0; deq_req = 1'b0;
        $display("soak: 10000 cycles done, final occ=%0d", occupancy);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/wrr_pifo_dequeue.md
Name: wrr_pifo_dequeue

Overview:
- Dequeue-side companion to the WRR rank engine.
- Holds WRR rank words in a sorted shift-register PIFO and releases the smallest rank on request.
- On every pop, feeds the popped overflow/round back as the "last dequeued" global round, which the rank engine uses for its outdated-class check.
- Sits between the rank engine's response port and the output scheduler.

Parameters:
- DEPTH, 16, number of PIFO slots (power of two, ≥2).
- PIFO_OVERFLOW_WIDTH, 1, overflow (epoch) bit width.
- PIFO_ROUND_WIDTH, 18, round field width.
- PIFO_ADDR_WIDTH, 12, address/tag field width.
- PIFO_WIDTH, 32, rank word width; must equal 1 + PIFO_OVERFLOW_WIDTH + PIFO_ROUND_WIDTH + PIFO_ADDR_WIDTH.
- COUNT_WIDTH, 5, occupancy counter width; must be ≥ log2(DEPTH)+1.

Ports:
- clk  in  1  single clock, rising edge.
- rstn  in  1  asynchronous, active-low reset.
- enq_valid  in  1  rank word offered.
- enq_ready  out  1  slot available this cycle.
- enq_data  in  PIFO_WIDTH  rank word: {valid, overflow, round, addr}, MSB first.
- deq_req  in  1  pop request (pull).
- deq_valid  out  1  popped word valid, one pulse.
- deq_data  out  PIFO_WIDTH  popped word.
- last_pifo_valid  out  1  popped-rank strobe to rank engine.
- last_pifo_overflow  out  PIFO_OVERFLOW_WIDTH  overflow of last popped rank.
- last_pifo_round  out  PIFO_ROUND_WIDTH  round of last popped rank.
- occupancy  out  COUNT_WIDTH  current entry count.

Behaviour:
- Reset: asynchronous, active-low.
  - All slot valid bits are cleared, occupancy is 0 and enq_ready is 0.
  - deq_valid, deq_data, last_pifo_valid, last_pifo_overflow and last_pifo_round are all 0.
  - Reset asserted mid-operation discards every stored entry immediately.
  - The first cycle after release behaves as an empty queue, with enq_ready=1.
- Ordering key: K = {overflow, round}, width W = PIFO_OVERFLOW_WIDTH + PIFO_ROUND_WIDTH.
  - A is earlier than B iff (K_A − K_B) mod 2^W has its MSB set (serial-number compare). This handles the engine's round wrap from ROUND_MAX to 0 with an overflow increment.
  - Equal keys keep arrival order (FIFO among ties).
  - The addr field is carried only and never compared.
- Enqueue accept: enq_fire = enq_valid & enq_ready.
  - enq_ready = (occupancy < DEPTH) | deq_req, so a pop frees a slot for a same-cycle insert when full.
  - When empty, a same-cycle enq+deq does not bypass: the pop is ignored and the insert is stored.
  - The enq_data valid bit is not checked; the word is stored as given.
- Pop: deq_fire = deq_req & (occupancy ≠ 0). deq_req with an empty queue is ignored and no output pulse is produced.
- Latency:
  - Pop: deq_valid and deq_data register the head slot one cycle after deq_fire.
  - Feedback: in the same cycle, last_pifo_valid pulses and last_pifo_overflow/last_pifo_round take that word's fields.
  - last_pifo_overflow and last_pifo_round hold their value until the next pop.
  - An enqueued entry is visible as head and occupancy one cycle after enq_fire.
- Slot update each cycle; slot 0 is the head.
  - Pop only: every slot shifts toward the head by one.
  - Insert only: position p is the count of valid entries not later than the new key. Slots ≥ p shift away from the head and the new word goes in slot p.
  - Pop + insert: p is computed against the post-pop array (entries 1..n−1), and both are applied in one cycle.
- Occupancy:
  - +1 on insert only, −1 on pop only, unchanged on both.
  - Never exceeds DEPTH and never underflows.
- Compare fan-out: DEPTH parallel comparators in one cycle; no further internal pipelining.

Decomposition:
- Shared package wrr_pifo_pkg holds:
  - the rank field widths and bit offsets (VALID_BIT, OVF_MSB/LSB, ROUND_MSB/LSB, ADDR_MSB/LSB);
  - ROUND_MAX;
  - the serial-compare function rank_before(a, b).
  - The rank engine adopts the same package.
- One natural sub-module: pifo_slot, one storage cell per index. It holds the valid bit and word, and selects among hold, take-from-neighbour, take-new and shift-toward-head using the broadcast insert position and pop flag.

Test Plan:
- Reset/empty: rstn=0 mid-stream with 5 stored entries → occupancy=0, all outputs 0. Then deq_req=1 with empty queue → no deq_valid, last_pifo_valid=0.
- Sorted pop: enqueue rounds 7, 3, 5, 3 (addrs 1, 2, 3, 4; overflow 0); pop four times → deq addrs 2, 4, 3, 1 in that order; last_pifo_round 3, 3, 5, 7, each one cycle after its deq_req.
- Wrap order: enqueue {ovf0, round 0x3FFFF} then {ovf1, round 0}; pop twice → 0x3FFFF first, then {1, 0}; last_pifo_overflow goes 0 → 1.
- Full + simultaneous: fill 16 entries of round 10 → enq_ready=0. Then assert enq of round 2 together with deq_req → enq_ready=1, head popped, occupancy stays 16, the next pop returns round 2.
- Empty + simultaneous: with an empty queue, enq round 9 and deq_req in the same cycle → no deq_valid; next cycle occupancy=1 with head round 9.
- Random soak: 10k cycles of random enq/deq compared against a sorted-list model with stable tie-break. deq_data, occupancy and the last_pifo_* outputs must match every cycle.
